// File: rtl/reg_bus_arbiter_pkg.sv
// Shared widths, defaults and FSM state type for the two-port register bus arbiter.
package reg_bus_arbiter_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int GAP_W  = 4;

    localparam logic [ADDR_W-1:0] RSVD_ADDR_DEFAULT = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the priority pointer is owned by the caller.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic pri,
    output logic winner,
    output logic valid
);

    // A lone request always wins; the pointer only breaks ties.
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = pri;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-requester write arbiter feeding a register bank: grant, one issue cycle, then GAP holdoff cycles.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int                GAP       = 2,
    parameter logic [ADDR_W-1:0] RSVD_ADDR = RSVD_ADDR_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] DATA0,
    output logic              ACK0,
    input  logic              REQ1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] DATA1,
    output logic              ACK1,
    output logic              NAK,
    output logic              STB,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DOUT,
    output logic              GNT,
    output logic              BUSY
);

    state_t             state;
    state_t             next_state;
    logic [GAP_W-1:0]   cnt;
    logic               pri;
    logic               win;
    logic               win_valid;
    logic               grant;
    logic               stb_d;
    logic               nak_d;
    logic               ack0_d;
    logic               ack1_d;
    logic               busy_d;

    rr_arb2 u_arb (
        .req0   (REQ0),
        .req1   (REQ1),
        .pri    (pri),
        .winner (win),
        .valid  (win_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (win_valid) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_HOLD;
            ST_HOLD:  if (cnt == '0) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered views of the current state, so they trail it by one cycle.
    always_comb begin
        grant  = (state == ST_IDLE) && win_valid;
        stb_d  = (state == ST_ISSUE) && (ADDR != RSVD_ADDR);
        nak_d  = (state == ST_ISSUE) && (ADDR == RSVD_ADDR);
        ack0_d = (state == ST_ISSUE) && !GNT;
        ack1_d = (state == ST_ISSUE) && GNT;
        busy_d = (state != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            STB  <= 1'b0;
            NAK  <= 1'b0;
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            BUSY <= 1'b0;
            GNT  <= 1'b0;
            ADDR <= '0;
            DOUT <= '0;
            pri  <= 1'b0;
            cnt  <= '0;
        end else begin
            STB  <= stb_d;
            NAK  <= nak_d;
            ACK0 <= ack0_d;
            ACK1 <= ack1_d;
            BUSY <= busy_d;
            if (grant) begin
                ADDR <= win ? ADDR1 : ADDR0;
                DOUT <= win ? DATA1 : DATA0;
                GNT  <= win;
                pri  <= ~win;
            end
            if (state == ST_ISSUE) begin
                cnt <= GAP_W'(GAP - 1);
            end else if ((state == ST_HOLD) && (cnt != '0)) begin
                cnt <= cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench: transaction-level timing model of the arbiter plus directed and random scenarios.
module tb_reg_bus_arbiter;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [6:0] addr0 = '0, addr1 = '0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ack0, ack1, nak, stb, gnt, busy;
    logic [6:0] addr;
    logic [7:0] dout;

    logic       g1_rst = 1'b1;
    logic       g1_req0 = 1'b0;
    logic [6:0] g1_addr0 = '0;
    logic [7:0] g1_data0 = '0;
    logic       g1_ack0, g1_ack1, g1_nak, g1_stb, g1_gnt, g1_busy;
    logic [6:0] g1_addr;
    logic [7:0] g1_dout;

    int checks = 0;
    int errors = 0;

    // Model state: edge index, pointer, next edge the arbiter may grant, issue edge, last grant edge.
    int         e = 0;
    int         m_pri = 0;
    int         m_free = 0;
    int         m_issue = -1;
    int         m_grant = -100;
    logic       m_gnt = 1'b0;
    logic [6:0] m_addr = '0;
    logic [7:0] m_dout = '0;
    logic       exp_stb = 1'b0, exp_ack0 = 1'b0, exp_ack1 = 1'b0, exp_nak = 1'b0, exp_busy = 1'b0;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.GAP(GAP), .RSVD_ADDR(7'h7F)) dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .ADDR0(addr0), .DATA0(data0), .ACK0(ack0),
        .REQ1(req1), .ADDR1(addr1), .DATA1(data1), .ACK1(ack1),
        .NAK(nak), .STB(stb), .ADDR(addr), .DOUT(dout), .GNT(gnt), .BUSY(busy)
    );

    reg_bus_arbiter #(.GAP(1), .RSVD_ADDR(7'h7F)) dut_g1 (
        .CLK(clk), .RST(g1_rst),
        .REQ0(g1_req0), .ADDR0(g1_addr0), .DATA0(g1_data0), .ACK0(g1_ack0),
        .REQ1(1'b0), .ADDR1(7'h00), .DATA1(8'h00), .ACK1(g1_ack1),
        .NAK(g1_nak), .STB(g1_stb), .ADDR(g1_addr), .DOUT(g1_dout), .GNT(g1_gnt), .BUSY(g1_busy)
    );

    function automatic logic [20:0] obs_vec();
        return {stb, ack0, ack1, nak, busy, gnt, addr, dout};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {exp_stb, exp_ack0, exp_ack1, exp_nak, exp_busy, m_gnt, m_addr, m_dout};
    endfunction

    // Predicts the outputs visible after edge e from the inputs sampled at that edge.
    task automatic model_edge();
        int w;
        exp_stb = 1'b0; exp_ack0 = 1'b0; exp_ack1 = 1'b0; exp_nak = 1'b0;
        if (rst) begin
            m_pri = 0; m_free = e + 1; m_issue = -1; m_grant = -100;
            m_gnt = 1'b0; m_addr = '0; m_dout = '0;
        end else begin
            if (e == m_issue) begin
                if (m_addr == 7'h7F) exp_nak = 1'b1; else exp_stb = 1'b1;
                if (m_gnt) exp_ack1 = 1'b1; else exp_ack0 = 1'b1;
            end
            if (e >= m_free && (req0 || req1)) begin
                if (req0 && req1) w = m_pri; else w = req1 ? 1 : 0;
                m_pri   = 1 - w;
                m_gnt   = (w == 1);
                m_addr  = (w == 1) ? addr1 : addr0;
                m_dout  = (w == 1) ? data1 : data0;
                m_issue = e + 1;
                m_free  = e + 2 + GAP;
                m_grant = e;
            end
        end
        exp_busy = !rst && (e >= m_grant + 1) && (e <= m_grant + 1 + GAP);
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec() || obs_vec() !== 21'h0) begin
                errors++;
                $display("[TB] FAIL reset got=%h want=%h", obs_vec(), 21'h0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        req0 = 1'b1; addr0 = 7'h05; data0 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (exp_ack0) req0 = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL single_write edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_contention();
        int stb_t[$];
        logic stb_g[$];
        rst = 1'b1; tick(); rst = 1'b0;
        req0 = 1'b1; addr0 = 7'h10; data0 = 8'h3C;
        req1 = 1'b1; addr1 = 7'h20; data1 = 8'hC3;
        for (int t = 1; t <= 16; t++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL contention edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
            end
            if (stb === 1'b1) begin stb_t.push_back(t); stb_g.push_back(gnt); end
        end
        checks++;
        if (stb_t.size() != 4) begin
            errors++;
            $display("[TB] FAIL contention_count got=%0d want=4", stb_t.size());
        end
        for (int i = 0; i < stb_t.size() && i < 4; i++) begin
            checks++;
            if (stb_g[i] !== logic'(i % 2) || stb_t[i] != 2 + 4 * i) begin
                errors++;
                $display("[TB] FAIL contention_seq idx=%0d got gnt=%0d t=%0d want gnt=%0d t=%0d",
                         i, stb_g[i], stb_t[i], i % 2, 2 + 4 * i);
            end
        end
        idle(6);
    endtask

    task automatic test_reserved();
        int n_nak = 0, n_stb = 0, n_ack1 = 0;
        req1 = 1'b1; addr1 = 7'h7F; data1 = 8'h99;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (exp_ack1) req1 = 1'b0;
            n_nak += int'(nak); n_stb += int'(stb); n_ack1 += int'(ack1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reserved edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (n_nak != 1 || n_stb != 0 || n_ack1 != 1) begin
            errors++;
            $display("[TB] FAIL reserved_counts got nak=%0d stb=%0d ack1=%0d want 1 0 1", n_nak, n_stb, n_ack1);
        end
        req0 = 1'b1; addr0 = 7'h01; data0 = 8'h11;
        req1 = 1'b1; addr1 = 7'h02; data1 = 8'h22;
        tick(); tick();
        checks++;
        if ({ack0, ack1, gnt} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reserved_pri got=%b want=100", {ack0, ack1, gnt});
        end
        idle(6);
    endtask

    task automatic test_reset_mid_hold();
        int n_ack0 = 0, n_ack1 = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        req0 = 1'b1; addr0 = 7'h33; data0 = 8'h44;
        req1 = 1'b1; addr1 = 7'h55; data1 = 8'h66;
        tick(); tick();
        if (exp_ack0) req0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== 21'h0) begin
            errors++;
            $display("[TB] FAIL reset_hold_zero got=%h want=%h", obs_vec(), 21'h0);
        end
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (exp_ack1) req1 = 1'b0;
            n_ack0 += int'(ack0); n_ack1 += int'(ack1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reset_hold edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (n_ack0 != 0 || n_ack1 != 1) begin
            errors++;
            $display("[TB] FAIL reset_hold_acks got ack0=%0d ack1=%0d want 0 1", n_ack0, n_ack1);
        end
        idle(6);
    endtask

    task automatic test_withdrawn();
        int n_ack0 = 0, n_stb = 0;
        req1 = 1'b1; addr1 = 7'h0A; data1 = 8'h5A;
        addr0 = 7'h0B; data0 = 8'hB0;
        for (int t = 1; t <= 9; t++) begin
            req0 = (t == 3);
            tick();
            if (exp_ack1) req1 = 1'b0;
            n_ack0 += int'(ack0); n_stb += int'(stb);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL withdrawn edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (n_ack0 != 0 || n_stb != 1) begin
            errors++;
            $display("[TB] FAIL withdrawn_counts got ack0=%0d stb=%0d want 0 1", n_ack0, n_stb);
        end
        idle(4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1'b1; addr0 = 7'($urandom); data0 = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) addr0 = 7'h7F;
                end
            end else if ($urandom_range(0, 19) == 0) req0 = 1'b0;
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1'b1; addr1 = 7'($urandom); data1 = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) addr1 = 7'h7F;
                end
            end else if ($urandom_range(0, 19) == 0) req1 = 1'b0;
            tick();
            if (exp_ack0) req0 = 1'b0;
            if (exp_ack1) req1 = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
            end
        end
        idle(6);
    endtask

    task automatic test_gap1();
        logic [7:0] cur;
        logic       want;
        g1_rst = 1'b1; tick();
        g1_rst = 1'b0; g1_req0 = 1'b1; g1_addr0 = 7'h11;
        cur = 8'($urandom); g1_data0 = cur;
        for (int k = 1; k <= 15; k++) begin
            tick();
            want = (k >= 2) && ((k - 2) % 3 == 0);
            checks++;
            if (g1_stb !== want) begin
                errors++;
                $display("[TB] FAIL gap1_stb k=%0d got=%b want=%b", k, g1_stb, want);
            end
            if (want) begin
                checks++;
                if ({g1_ack0, g1_dout} !== {1'b1, cur}) begin
                    errors++;
                    $display("[TB] FAIL gap1_data k=%0d got ack=%b dout=%h want ack=1 dout=%h", k, g1_ack0, g1_dout, cur);
                end
                cur = 8'($urandom); g1_data0 = cur;
            end
        end
        g1_req0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_reserved();
        test_reset_mid_hold();
        test_withdrawn();
        test_random();
        test_gap1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
